// File: rtl/muldiv_unit_pkg.sv
// Shared encodings for the multiply/divide unit: op codes and FSM states.
package muldiv_unit_pkg;

    typedef enum logic [2:0] {
        MDU_MULT  = 3'd0,
        MDU_MULTU = 3'd1,
        MDU_DIV   = 3'd2,
        MDU_DIVU  = 3'd3,
        MDU_MTHI  = 3'd4,
        MDU_MTLO  = 3'd5
    } mdu_op_e;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_MUL  = 2'd1,
        S_DIV  = 2'd2,
        S_SIGN = 2'd3
    } mdu_state_e;

endpackage

// File: rtl/muldiv_unit_div_iter.sv
// One restoring-division step on magnitudes: shift the next dividend bit into
// the remainder, trial-subtract the divisor, and shift the quotient bit in.
module mdu_div_iter #(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] i_rem,
    input  logic [WIDTH-1:0] i_quo,
    input  logic [WIDTH-1:0] i_dvs,
    output logic [WIDTH-1:0] o_rem,
    output logic [WIDTH-1:0] o_quo
);
    logic [WIDTH:0]   w_shift;
    logic [WIDTH-1:0] w_diff;
    logic             w_ge;

    assign w_shift = {i_rem, i_quo[WIDTH-1]};
    assign w_ge    = (w_shift >= {1'b0, i_dvs});
    // Whenever the subtract is taken the true difference is below the divisor,
    // so the low WIDTH bits are exact.
    assign w_diff  = w_shift[WIDTH-1:0] - i_dvs;
    assign o_rem   = w_ge ? w_diff : w_shift[WIDTH-1:0];
    assign o_quo   = {i_quo[WIDTH-2:0], w_ge};
endmodule

// File: rtl/muldiv_unit.sv
// Iterative signed/unsigned multiply/divide with HI/LO registers and MTHI/MTLO.
// Define MULDIV_FAST_MUL_EN for a single-cycle native multiply (divide unchanged).
module muldiv_unit
    import muldiv_unit_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             start,
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             flush,
    output logic             busy,
    output logic             done,
    output logic             div_by_zero,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);
    localparam int CNT_W = $clog2(WIDTH) + 1;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);

    mdu_state_e         r_state, w_next;
    logic [CNT_W-1:0]   r_cnt;
    logic [WIDTH-1:0]   r_opnd;     // multiplicand (MUL) or divisor (DIV) magnitude
    logic [2*WIDTH-1:0] r_acc;      // product, or {remainder, quotient}
    logic               r_neg_q, r_neg_r, r_is_div, r_dbz;
    logic               r_done, r_dbz_o;
    logic [WIDTH-1:0]   r_hi, r_lo;

    logic             w_signed, w_sa, w_sb, w_is_mul, w_is_div, w_b_zero, w_accept;
    logic [WIDTH-1:0] w_abs_a, w_abs_b, w_rem_nxt, w_quo_nxt;

    assign w_is_mul = (op == MDU_MULT) || (op == MDU_MULTU);
    assign w_is_div = (op == MDU_DIV)  || (op == MDU_DIVU);
    assign w_signed = (op == MDU_MULT) || (op == MDU_DIV);
    assign w_sa     = w_signed & a[WIDTH-1];
    assign w_sb     = w_signed & b[WIDTH-1];
    assign w_abs_a  = w_sa ? -a : a;
    assign w_abs_b  = w_sb ? -b : b;
    assign w_b_zero = (b == '0);
    assign w_accept = start & ~flush & (r_state == S_IDLE);

`ifdef MULDIV_FAST_MUL_EN
    logic [2*WIDTH-1:0] w_prod;
    // Low 2*WIDTH bits of the extended product are the signed or unsigned result.
    assign w_prod = (op == MDU_MULT)
        ? {{WIDTH{a[WIDTH-1]}}, a} * {{WIDTH{b[WIDTH-1]}}, b}
        : {{WIDTH{1'b0}}, a} * {{WIDTH{1'b0}}, b};
`else
    logic [WIDTH:0]     w_mul_sum;
    logic [2*WIDTH-1:0] w_mul_nxt;
    assign w_mul_sum = {1'b0, r_acc[2*WIDTH-1:WIDTH]} + (r_acc[0] ? {1'b0, r_opnd} : '0);
    assign w_mul_nxt = {w_mul_sum, r_acc[WIDTH-1:1]};
`endif

    mdu_div_iter #(.WIDTH(WIDTH)) u_div_iter (
        .i_rem (r_acc[2*WIDTH-1:WIDTH]),
        .i_quo (r_acc[WIDTH-1:0]),
        .i_dvs (r_opnd),
        .o_rem (w_rem_nxt),
        .o_quo (w_quo_nxt)
    );

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE: if (w_accept) begin
                if (w_is_mul)      w_next = S_MUL;
                else if (w_is_div) w_next = w_b_zero ? S_SIGN : S_DIV;
            end
`ifdef MULDIV_FAST_MUL_EN
            S_MUL:  w_next = S_IDLE;
`else
            S_MUL:  if (r_cnt == LAST) w_next = S_SIGN;
`endif
            S_DIV:  if (r_cnt == LAST) w_next = S_SIGN;
            S_SIGN: w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
        if (flush && r_state != S_IDLE) w_next = S_IDLE;
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) r_state <= S_IDLE;
        else       r_state <= w_next;
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_cnt <= '0; r_opnd <= '0; r_acc <= '0;
            r_neg_q <= 1'b0; r_neg_r <= 1'b0; r_is_div <= 1'b0; r_dbz <= 1'b0;
            r_done <= 1'b0; r_dbz_o <= 1'b0; r_hi <= '0; r_lo <= '0;
        end else begin
            r_done  <= 1'b0;
            r_dbz_o <= 1'b0;
            case (r_state)
                S_IDLE: if (w_accept) begin
                    if (w_is_mul || w_is_div) begin
                        r_cnt    <= '0;
                        r_neg_q  <= w_sa ^ w_sb;
                        r_neg_r  <= w_sa;
                        r_is_div <= w_is_div;
                        r_dbz    <= w_is_div & w_b_zero;
                        if (w_is_mul) begin
                            r_opnd <= w_abs_a;
`ifdef MULDIV_FAST_MUL_EN
                            r_acc  <= w_prod;
`else
                            r_acc  <= {{WIDTH{1'b0}}, w_abs_b};
`endif
                        end else begin
                            r_opnd <= w_abs_b;
                            // Divide by zero preloads the final {hi, lo} = {a, all ones}.
                            r_acc  <= w_b_zero ? {a, {WIDTH{1'b1}}} : {{WIDTH{1'b0}}, w_abs_a};
                        end
                    end else if (op == MDU_MTHI) begin
                        r_hi   <= a;
                        r_done <= 1'b1;
                    end else if (op == MDU_MTLO) begin
                        r_lo   <= a;
                        r_done <= 1'b1;
                    end
                end
                S_MUL: begin
`ifdef MULDIV_FAST_MUL_EN
                    if (!flush) begin
                        {r_hi, r_lo} <= r_acc;
                        r_done       <= 1'b1;
                    end
`else
                    r_acc <= w_mul_nxt;
                    r_cnt <= r_cnt + 1'b1;
`endif
                end
                S_DIV: begin
                    r_acc <= {w_rem_nxt, w_quo_nxt};
                    r_cnt <= r_cnt + 1'b1;
                end
                S_SIGN: if (!flush) begin
                    r_done <= 1'b1;
                    if (r_dbz) begin
                        {r_hi, r_lo} <= r_acc;
                        r_dbz_o      <= 1'b1;
                    end else if (r_is_div) begin
                        r_hi <= r_neg_r ? -r_acc[2*WIDTH-1:WIDTH] : r_acc[2*WIDTH-1:WIDTH];
                        r_lo <= r_neg_q ? -r_acc[WIDTH-1:0] : r_acc[WIDTH-1:0];
                    end else begin
                        {r_hi, r_lo} <= r_neg_q ? -r_acc : r_acc;
                    end
                end
                default: ;
            endcase
        end
    end

    assign busy        = (r_state != S_IDLE);
    assign done        = r_done;
    assign div_by_zero = r_dbz_o;
    assign hi          = r_hi;
    assign lo          = r_lo;
endmodule

// File: tb/tb_muldiv_unit.sv
// Directed self-checking bench for muldiv_unit (default iterative build, WIDTH=32).
module tb_muldiv_unit;
    import muldiv_unit_pkg::*;

    logic        clk = 1'b0, rstn = 1'b0, start = 1'b0, flush = 1'b0;
    logic [2:0]  op = 3'd0;
    logic [31:0] a = '0, b = '0;
    logic        busy, done, div_by_zero;
    logic [31:0] hi, lo;
    int          n_chk = 0, n_err = 0;
    int          lat, bcnt, dc;

    muldiv_unit #(.WIDTH(32)) dut (
        .clk(clk), .rstn(rstn), .start(start), .op(op), .a(a), .b(b), .flush(flush),
        .busy(busy), .done(done), .div_by_zero(div_by_zero), .hi(hi), .lo(lo)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic issue(input logic [2:0] o, input logic [31:0] aa, input logic [31:0] bb);
        @(negedge clk);
        start = 1'b1; op = o; a = aa; b = bb;
        @(negedge clk);
        start = 1'b0;
    endtask

    // Returns in the done cycle; lat counts negedges since acceptance (1 = first cycle after).
    task automatic run(input logic [2:0] o, input logic [31:0] aa, input logic [31:0] bb,
                       output int l, output int bc);
        issue(o, aa, bb);
        l = 1; bc = 0;
        while (!done && l < 100) begin
            if (busy) bc++;
            @(negedge clk);
            l++;
        end
        check("done_seen", {63'd0, done}, 64'd1);
    endtask

    initial begin
        repeat (2) @(negedge clk);
        check("rst_hilo", {hi, lo}, 64'd0);
        check("rst_flags", {61'd0, busy, done, div_by_zero}, 64'd0);
        rstn = 1'b1;

        run(3'(MDU_MULTU), 32'hFFFF_FFFF, 32'd2, lat, bcnt);
        check("multu_hilo", {hi, lo}, 64'h0000_0001_FFFF_FFFE);
        check("multu_lat", 64'(lat), 64'd34);
        check("multu_busy_cycles", 64'(bcnt), 64'd33);
        check("multu_busy_at_done", {63'd0, busy}, 64'd0);
        @(negedge clk);
        check("multu_done_pulse", {63'd0, done}, 64'd0);

        run(3'(MDU_MULT), 32'hFFFF_FFFD, 32'd7, lat, bcnt);
        check("mult_hilo", {hi, lo}, 64'hFFFF_FFFF_FFFF_FFEB);

        run(3'(MDU_DIVU), 32'd7, 32'd2, lat, bcnt);
        check("divu_hilo", {hi, lo}, 64'h0000_0001_0000_0003);
        check("divu_dbz", {63'd0, div_by_zero}, 64'd0);

        run(3'(MDU_DIV), 32'hFFFF_FFF9, 32'd2, lat, bcnt);
        check("div_neg_hilo", {hi, lo}, 64'hFFFF_FFFF_FFFF_FFFD);
        check("div_neg_lat", 64'(lat), 64'd34);

        run(3'(MDU_DIV), 32'h8000_0000, 32'hFFFF_FFFF, lat, bcnt);
        check("div_ovf_hilo", {hi, lo}, 64'h0000_0000_8000_0000);
        check("div_ovf_dbz", {63'd0, div_by_zero}, 64'd0);

        run(3'(MDU_DIV), 32'd5, 32'd0, lat, bcnt);
        check("dbz_hilo", {hi, lo}, 64'h0000_0005_FFFF_FFFF);
        check("dbz_flag", {63'd0, div_by_zero}, 64'd1);
        check("dbz_lat", 64'(lat), 64'd2);

        // Flush mid-divide; an MTHI start while busy must be ignored.
        issue(3'(MDU_DIVU), 32'd100, 32'd3);
        repeat (3) @(negedge clk);
        start = 1'b1; op = 3'(MDU_MTHI); a = 32'hDEAD_BEEF;
        @(negedge clk);
        start = 1'b0;
        repeat (5) @(negedge clk);
        check("flush_busy_before", {63'd0, busy}, 64'd1);
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        check("flush_busy_after", {63'd0, busy}, 64'd0);
        dc = 0;
        repeat (40) begin @(negedge clk); if (done) dc++; end
        check("flush_no_done", 64'(dc), 64'd0);
        check("flush_hilo_kept", {hi, lo}, 64'h0000_0005_FFFF_FFFF);

        // Asynchronous reset mid-multiply, then MTHI.
        issue(3'(MDU_MULT), 32'd3, 32'd5);
        repeat (5) @(negedge clk);
        rstn = 1'b0;
        #1;
        check("rst_mid_hilo", {hi, lo}, 64'd0);
        check("rst_mid_flags", {62'd0, busy, done}, 64'd0);
        @(negedge clk);
        rstn = 1'b1;
        dc = 0;
        repeat (40) begin @(negedge clk); if (done || busy) dc++; end
        check("rst_no_done", 64'(dc), 64'd0);

        issue(3'(MDU_MTHI), 32'h0000_1234, 32'd0);
        check("mthi_hi", 64'(hi), 64'h1234);
        check("mthi_done", {62'd0, done, busy}, 64'd2);
        @(negedge clk);
        check("mthi_after", {62'd0, done, busy}, 64'd0);

        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end
endmodule
